// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory bus arbiter.
package mem_arb_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      I_ADDR = 3'd1,
      I_DATA = 3'd2,
      D_ADDR = 3'd3,
      D_DATA = 3'd4
   } arb_state_t;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/mem_arb_hold.sv
// Per-port completion holder: keeps the read result and done flag until the whole pipeline advances.
module mem_arb_hold
   import mem_arb_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              req,
   input  logic              complete,
   input  logic [DATA_W-1:0] rdata_in,
   input  logic              release_en,
   output logic [DATA_W-1:0] rdata,
   output logic              stall
);

   logic done;

   // Completion wins over release; a port only completes while it is itself stalling.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         done  <= 1'b0;
         rdata <= '0;
      end else if (complete) begin
         done  <= 1'b1;
         rdata <= rdata_in;
      end else if (release_en) begin
         done  <= 1'b0;
      end
   end

   assign stall = req & ~done;

endmodule

// File: rtl/mem_arbiter.sv
// Serializes fetch and load/store accesses onto one SRAM-like bus, data port first.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              inst_req,
   input  logic [ADDR_W-1:0] inst_addr,
   output logic [DATA_W-1:0] inst_rdata,
   input  logic              data_req,
   input  logic              data_wr,
   input  logic [1:0]        data_size,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [DATA_W-1:0] data_wdata,
   output logic [DATA_W-1:0] data_rdata,
   output logic              bus_req,
   output logic              bus_wr,
   output logic [1:0]        bus_size,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic              bus_addr_ok,
   input  logic              bus_data_ok,
   input  logic [DATA_W-1:0] bus_rdata,
   output logic              i_stall,
   output logic              d_stall,
   output logic              longest_stall
);

   arb_state_t state;
   logic       i_complete;
   logic       d_complete;
   logic       release_en;

   // A combined addr_ok/data_ok in the address phase completes without a data-phase cycle.
   assign i_complete = bus_data_ok & ((state == I_DATA) | ((state == I_ADDR) & bus_addr_ok));
   assign d_complete = bus_data_ok & ((state == D_DATA) | ((state == D_ADDR) & bus_addr_ok));

   assign longest_stall = i_stall | d_stall;
   assign release_en    = ~longest_stall;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         bus_req   <= 1'b0;
         bus_wr    <= 1'b0;
         bus_size  <= SZ_BYTE;
         bus_addr  <= '0;
         bus_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (d_stall) begin
                  state     <= D_ADDR;
                  bus_req   <= 1'b1;
                  bus_wr    <= data_wr;
                  bus_size  <= data_size;
                  bus_addr  <= data_addr;
                  bus_wdata <= data_wdata;
               end else if (i_stall) begin
                  state     <= I_ADDR;
                  bus_req   <= 1'b1;
                  bus_wr    <= 1'b0;
                  bus_size  <= SZ_WORD;
                  bus_addr  <= inst_addr;
                  bus_wdata <= '0;
               end
            end
            I_ADDR: begin
               if (bus_addr_ok) begin
                  bus_req <= 1'b0;
                  state   <= bus_data_ok ? IDLE : I_DATA;
               end
            end
            D_ADDR: begin
               if (bus_addr_ok) begin
                  bus_req <= 1'b0;
                  state   <= bus_data_ok ? IDLE : D_DATA;
               end
            end
            I_DATA, D_DATA: begin
               if (bus_data_ok) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   mem_arb_hold #(.DATA_W(DATA_W)) u_inst_hold (
      .clk        (clk),
      .resetn     (resetn),
      .req        (inst_req),
      .complete   (i_complete),
      .rdata_in   (bus_rdata),
      .release_en (release_en),
      .rdata      (inst_rdata),
      .stall      (i_stall)
   );

   mem_arb_hold #(.DATA_W(DATA_W)) u_data_hold (
      .clk        (clk),
      .resetn     (resetn),
      .req        (data_req),
      .complete   (d_complete),
      .rdata_in   (bus_rdata),
      .release_en (release_en),
      .rdata      (data_rdata),
      .stall      (d_stall)
   );

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one SRAM-like memory bus between the instruction-fetch port and the data (MEM stage) port of the 5-stage MIPS core. It serializes requests one transaction at a time, with data priority. It generates the `i_stall` and `d_stall` inputs of the hazard unit, plus the global `longest_stall`. Completed results are held until the whole pipeline is released, so no access is ever reissued while the other port is still pending.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous active-low reset.
- `inst_req`  in  1  fetch request; held high until serviced.
- `inst_addr`  in  ADDR_W  fetch address; stable while `inst_req`.
- `inst_rdata`  out  DATA_W  fetched word; valid while `inst_done`.
- `data_req`  in  1  load/store request; held high until serviced.
- `data_wr`  in  1  1 = store.
- `data_size`  in  2  0 = byte, 1 = half, 2 = word.
- `data_addr`  in  ADDR_W  data address.
- `data_wdata`  in  DATA_W  store data.
- `data_rdata`  out  DATA_W  load data; valid while `data_done`.
- `bus_req`, `bus_wr`, `bus_size`, `bus_addr`, `bus_wdata`  out  1/1/2/ADDR_W/DATA_W  downstream request, all registered.
- `bus_addr_ok`  in  1  downstream accepted the address phase.
- `bus_data_ok`  in  1  downstream finished; `bus_rdata` valid.
- `bus_rdata`  in  DATA_W  downstream read data.
- `i_stall`  out  1  equals `inst_req & ~inst_done`.
- `d_stall`  out  1  equals `data_req & ~data_done`.
- `longest_stall`  out  1  equals `i_stall | d_stall`.

## Operation
- FSM states: IDLE, I_ADDR, I_DATA, D_ADDR, D_DATA.
- **IDLE, grant selection:**
  - If a data request is pending (`data_req & ~data_done`), go to D_ADDR.
  - Else if a fetch request is pending (`inst_req & ~inst_done`), go to I_ADDR.
  - Data wins a tie, because it belongs to the older instruction.
- **At grant:** latch `bus_addr`, `bus_wr`, `bus_size` and `bus_wdata` from the winning port.
  - A fetch is always a read with size 2.
  - Set `bus_req` = 1 in the next cycle.
- **X_ADDR:** hold `bus_req` high.
  - On `bus_addr_ok`, clear `bus_req` and go to X_DATA.
  - If `bus_addr_ok` and `bus_data_ok` arrive in the same cycle, complete directly and go to IDLE.
- **X_DATA:** on `bus_data_ok`, capture `bus_rdata` into the port's holding register, set the port's done flag, and go to IDLE.
- **Done flags** (`inst_done`, `data_done`):
  - Each flag clears on the edge where `longest_stall` = 0, which is when the pipeline advances.
  - While a flag is set, that port is not re-arbitrated.
- `bus_data_ok` in IDLE is ignored.
- `bus_addr_ok` outside X_ADDR is ignored.

## Timing
- **Reset values:**
  - State = IDLE.
  - `bus_req`, `bus_wr`, `bus_size`, `bus_addr`, `bus_wdata` = 0.
  - Done flags = 0.
  - `inst_rdata`, `data_rdata` = 0.
  - With no requests, `i_stall`, `d_stall`, `longest_stall` = 0.
- **Minimum latency** (request first seen in IDLE at cycle 0):
  - Cycle 1: `bus_req` high.
  - Cycle 1: `bus_addr_ok` returned.
  - Cycle 2: `bus_data_ok` returned.
  - Cycle 3: done flag set, stall low.
- **Back-to-back:** at least one IDLE cycle separates transactions.
- **Both ports requesting** (minimum bus latency):
  - Data completes with `data_done` visible at cycle 3.
  - Fetch is granted from IDLE at cycle 3; `inst_done` is visible at cycle 6.
  - `longest_stall` stays high through cycle 5 and is low at cycle 6.
  - `data_done` holds from cycle 3 until the cycle-6 edge.
- **Stall outputs** are combinational from `*_req` and the done flags; the stall outputs have no path from bus inputs.
- **Asynchronous reset mid-transaction:** the FSM returns to IDLE immediately and the in-flight result is discarded. The downstream bus shares `resetn`.

## Structure
- **`mem_arb_pkg`:**
  - state enum `arb_state_t`.
  - size constants `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`.
- **Sub-module `mem_arb_hold`,** instantiated twice (inst, data). It contains:
  - the done flag;
  - the rdata holding register;
  - the stall output.

  Inputs: `req`, `complete`, `rdata_in`, `release` (= ~`longest_stall`).
- The top level contains the FSM, the grant mux and the bus output registers.

## Test plan
- **Fetch only:** `inst_addr`=0xBFC00000, `bus_addr_ok` at cycle 1, `bus_data_ok` at cycle 2 with `bus_rdata`=0x24080001 -> `bus_addr`=0xBFC00000, `bus_wr`=0, `bus_size`=2; `inst_rdata`=0x24080001 and `i_stall`=0 at cycle 3.
- **Simultaneous requests** (fetch 0x100, store 0x2000 with wdata 0xDEADBEEF, size 2) -> store is issued first. Fetch is granted at cycle 3. `longest_stall` stays high until `inst_done` at cycle 6, and no second store is issued.
- **Combined handshake:** `bus_addr_ok` and `bus_data_ok` asserted in the same cycle in D_ADDR -> completion with no D_DATA cycle; `data_done` visible next cycle.
- **Slow bus:** `bus_addr_ok` withheld 5 cycles -> `bus_req`, `bus_addr` and `bus_size` stay constant; stall stays high.
- **Reset mid-transaction:** `resetn` low during I_DATA -> all outputs take reset values asynchronously. After release, a new fetch proceeds normally.
